run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of the monitored PC.
REQ-002 SHALL have parameter CNT_W, default 32, width of the cycle and retire counters.
REQ-003 SHALL have parameter RST_CYCLES, default 1, number of cycles cpu_reset is held (range 1..255).
REQ-004 SHALL have parameter MAX_CYCLES, default 2000, run-cycle budget before timeout.
REQ-005 SHALL have parameter HALT_REPEAT, default 4, number of consecutive equal valid PCs that signals a halt (range 2..15).
REQ-006 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-low block reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins a run.
REQ-009 SHALL have port abort  in  1  returns the block to IDLE from any state.
REQ-010 SHALL have port pc  in  PC_W  current fetch PC of the CPU under control.
REQ-011 SHALL have port pc_valid  in  1  qualifies pc.
REQ-012 SHALL have port retire  in  1  one instruction retired this cycle.
REQ-013 SHALL have port cpu_reset  out  1  active-high synchronous reset driven to the CPU.
REQ-014 SHALL have port running  out  1  high in RUN only.
REQ-015 SHALL have ports done and timeout  out  1 each  sticky end-of-run flags.
REQ-016 SHALL have ports cycle_cnt and retire_cnt  out  CNT_W each, plus halt_pc  out  PC_W.

Function
REQ-017 SHALL implement states IDLE, RST_HOLD, RUN, DONE, TMO, all registered outputs.
REQ-018 IDLE: cpu_reset=1; start -> RST_HOLD, clearing cycle_cnt, retire_cnt, halt_pc, done, timeout and the halt detector.
REQ-019 RST_HOLD: cpu_reset=1 for exactly RST_CYCLES cycles, then -> RUN; first RUN cycle shows cpu_reset=0.
REQ-020 RUN: running=1, cycle_cnt +1 per cycle, retire_cnt +1 per retire cycle; both saturate at all-ones.
REQ-021 Halt: a pc_valid sample equal to the previous valid sample increments a repeat count; an unequal sample resets it to 0; invalid cycles leave it unchanged.
REQ-022 RUN -> DONE when the repeat count reaches HALT_REPEAT-1; halt_pc latches that pc, done=1.
REQ-023 RUN -> TMO when cycle_cnt equals MAX_CYCLES-1 at a clock edge; timeout=1.
REQ-024 Halt and timeout in the same cycle: DONE wins; timeout stays 0.
REQ-025 DONE/TMO: cpu_reset=1, counters frozen, flags held; start restarts exactly as from IDLE.
REQ-026 start during RST_HOLD or RUN SHALL be ignored.
REQ-027 abort SHALL take priority over start, halt and timeout; next state IDLE, counters held for readout.

Reset
REQ-028 reset=0 at a clock edge: state IDLE, cpu_reset=1, running=0, done=0, timeout=0, all counters and halt_pc 0, independent of current state, including mid-run.

Configuration
REQ-029 With RUN_CTRL_PERF_EN defined, retire_cnt SHALL count per REQ-020.
REQ-030 Without RUN_CTRL_PERF_EN, retire_cnt SHALL be constant 0, the retire input SHALL be ignored, and no counter flops SHALL exist for it.

Structure
REQ-031 Package run_ctrl_pkg SHALL hold the state enum and the parameter default constants.
REQ-032 Sub-module run_halt_det SHALL own the previous-PC register and the repeat counter; its outputs are halt and halt_pc.

Verification
REQ-033 Reset with RST_CYCLES=3, pulse start -> cpu_reset high for exactly 3 cycles after start, then running=1.
REQ-034 pc sequence 0x3000, 0x3004, then 0x3008 held valid -> done=1 on the 4th 0x3008 sample, halt_pc=0x3008.
REQ-035 pc increments every cycle, MAX_CYCLES=2000 -> timeout=1 with cycle_cnt=1999, done=0, cpu_reset=1.
REQ-036 4th equal PC coincides with cycle_cnt=MAX_CYCLES-1 -> done=1, timeout=0.
REQ-037 abort and then reset=0 mid-RUN -> IDLE with cpu_reset=1; after reset all outputs 0 except cpu_reset=1.
REQ-038 Build with RUN_CTRL_PERF_EN, retire on 10 cycles -> retire_cnt=10; without the macro -> retire_cnt=0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared constants for the run controller: parameter defaults, FSM state
// encodings and internal counter widths.
package run_ctrl_pkg;

    // Parameter defaults
    localparam int unsigned PC_W_DEF        = 32;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned RST_CYCLES_DEF  = 1;
    localparam int unsigned MAX_CYCLES_DEF  = 2000;
    localparam int unsigned HALT_REPEAT_DEF = 4;

    // Internal widths: hold counter covers RST_CYCLES up to 255,
    // repeat counter covers HALT_REPEAT up to 15.
    localparam int unsigned ST_W   = 3;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned REP_W  = 4;

    typedef logic [ST_W-1:0] state_t;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RST_HOLD = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_TMO      = 3'd4;

endpackage

// File: rtl/run_halt_det.sv
// Halt detector: tracks the previous valid PC and a count of consecutive
// equal valid samples. halt is asserted combinationally in the cycle whose
// sample brings the repeat count to HALT_REPEAT-1; halt_pc captures that pc.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   clr           clears history and halt_pc (start of a run)
//   en            detector active (RUN, no abort)
//   pc, pc_valid  monitored fetch PC and its qualifier
//   halt          halt condition this cycle
//   halt_pc       PC captured at the halt
module run_halt_det
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned HALT_REPEAT = HALT_REPEAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [PC_W-1:0] pc,
    input  logic            pc_valid,
    output logic            halt,
    output logic [PC_W-1:0] halt_pc
);

    logic [PC_W-1:0]  prev_q;
    logic             prev_vld_q;
    logic [REP_W-1:0] rep_q;
    logic             same;

    // Current valid sample repeats the previous valid sample
    assign same = en && pc_valid && prev_vld_q && (pc == prev_q);
    assign halt = same && (rep_q == REP_W'(HALT_REPEAT - 2));

    // History update; invalid cycles leave everything untouched
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rep_q      <= '0;
            halt_pc    <= '0;
        end else if (en && pc_valid) begin
            prev_q     <= pc;
            prev_vld_q <= 1'b1;
            rep_q      <= same ? rep_q + REP_W'(1) : '0;
            if (halt) begin
                halt_pc <= pc;
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds a CPU in reset, releases it for a bounded run and
// ends the run on a detected halt (repeated PC) or on a cycle budget.
// Optional retire counter is built only when RUN_CTRL_PERF_EN is defined;
// otherwise retire_cnt is tied to 0 and retire is ignored.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, abort        run start pulse, return-to-idle request
//   pc, pc_valid        monitored CPU fetch PC
//   retire              one instruction retired this cycle
//   cpu_reset           active-high reset to the CPU
//   running             high while in RUN
//   done, timeout       sticky end-of-run flags
//   cycle_cnt           RUN cycles elapsed
//   retire_cnt          instructions retired in RUN
//   halt_pc             PC at which the halt was detected
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = PC_W_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF,
    parameter int unsigned MAX_CYCLES  = MAX_CYCLES_DEF,
    parameter int unsigned HALT_REPEAT = HALT_REPEAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    input  logic             retire,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [PC_W-1:0]  halt_pc
);

    state_t            state_q, state_nxt;
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic [CNT_W-1:0]  cyc_nxt;
    logic              done_nxt, timeout_nxt;
    logic              start_acc;
    logic              run_en;
    logic              halt;

    assign run_en = (state_q == ST_RUN) && !abort;

    run_halt_det #(
        .PC_W        (PC_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk      (clk),
        .reset    (reset),
        .clr      (start_acc),
        .en       (run_en),
        .pc       (pc),
        .pc_valid (pc_valid),
        .halt     (halt),
        .halt_pc  (halt_pc)
    );

    // Next state and next register values; abort overrides everything
    always_comb begin
        state_nxt   = state_q;
        hold_nxt    = hold_q;
        cyc_nxt     = cycle_cnt;
        done_nxt    = done;
        timeout_nxt = timeout;
        start_acc   = 1'b0;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_TMO: begin
                    if (start) begin
                        state_nxt   = ST_RST_HOLD;
                        start_acc   = 1'b1;
                        hold_nxt    = HOLD_W'(RST_CYCLES - 1);
                        cyc_nxt     = '0;
                        done_nxt    = 1'b0;
                        timeout_nxt = 1'b0;
                    end
                end
                ST_RST_HOLD: begin
                    if (hold_q == '0) begin
                        state_nxt = ST_RUN;
                    end else begin
                        hold_nxt = hold_q - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    // Halt beats timeout; cycle count freezes on the exit edge
                    if (halt) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else if (cycle_cnt == CNT_W'(MAX_CYCLES - 1)) begin
                        state_nxt   = ST_TMO;
                        timeout_nxt = 1'b1;
                    end else if (cycle_cnt != '1) begin
                        cyc_nxt = cycle_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            hold_q    <= hold_nxt;
            cycle_cnt <= cyc_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
            cpu_reset <= (state_nxt != ST_RUN);
            running   <= (state_nxt == ST_RUN);
        end
    end

`ifdef RUN_CTRL_PERF_EN
    // Retired-instruction counter, saturating
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge clk) begin
        if (!reset || start_acc) begin
            ret_q <= '0;
        end else if (run_en && retire && (ret_q != '1)) begin
            ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign retire_cnt = ret_q;
`else
    logic retire_unused;
    assign retire_unused = retire;
    assign retire_cnt    = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: reset, reset hold, halt detection, timeout,
// halt/timeout collision, retire counting, abort and mid-run reset.
module tb_run_ctrl;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic             retire;
    logic             cpu_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic [PC_W-1:0]  halt_pc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .PC_W        (PC_W),
        .CNT_W       (CNT_W),
        .RST_CYCLES  (3),
        .MAX_CYCLES  (2000),
        .HALT_REPEAT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .retire     (retire),
        .cpu_reset  (cpu_reset),
        .running    (running),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt),
        .halt_pc    (halt_pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse followed by the three hold cycles; leaves the DUT in RUN
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests++;
        if ({cpu_reset, running, done, timeout} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags: got cpu_reset/running/done/timeout=%b want 1000",
                     {cpu_reset, running, done, timeout});
        end
        tests++;
        if (cycle_cnt !== 0 || retire_cnt !== 0 || halt_pc !== 0) begin
            fails++;
            $display("FAIL reset_counters: got cyc=%0d ret=%0d hpc=%h want 0 0 0",
                     cycle_cnt, retire_cnt, halt_pc);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_rst_hold();
        logic [3:0] seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen[0] = cpu_reset;
        start = 1'b0;
        tick();
        seen[1] = cpu_reset;
        start = 1'b1;          // ignored during hold
        tick();
        start = 1'b0;
        seen[2] = cpu_reset;
        tick();
        seen[3] = cpu_reset;
        tests++;
        if (seen !== 4'b0111) begin
            fails++;
            $display("FAIL rst_hold_len: got cpu_reset seq(newest..oldest)=%b want 0111", seen);
        end
        tests++;
        if (running !== 1'b1 || cycle_cnt !== 0) begin
            fails++;
            $display("FAIL rst_hold_run: got running=%b cyc=%0d want 1 0", running, cycle_cnt);
        end
        start = 1'b1;          // ignored in RUN
        tick();
        start = 1'b0;
        tests++;
        if (running !== 1'b1 || cycle_cnt !== 1) begin
            fails++;
            $display("FAIL start_in_run: got running=%b cyc=%0d want 1 1", running, cycle_cnt);
        end
    endtask

    // Continues from RUN with cycle_cnt=1
    task automatic test_halt();
        pc_valid = 1'b1;
        pc = 32'h3000; tick();
        pc = 32'h3004; tick();
        pc = 32'h3008; tick(); tick(); tick();
        tests++;
        if (done !== 1'b0 || running !== 1'b1) begin
            fails++;
            $display("FAIL halt_early: got done=%b running=%b want 0 1", done, running);
        end
        tick();
        pc_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || halt_pc !== 32'h3008 || cpu_reset !== 1'b1 || running !== 1'b0) begin
            fails++;
            $display("FAIL halt_done: got done=%b hpc=%h cpu_reset=%b running=%b want 1 3008 1 0",
                     done, halt_pc, cpu_reset, running);
        end
        tests++;
        if (cycle_cnt !== 6 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL halt_cnt: got cyc=%0d timeout=%b want 6 0", cycle_cnt, timeout);
        end
    endtask

    // Restart from DONE; unequal sample resets the count, invalid cycles do not
    task automatic test_halt_invalid();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || halt_pc !== 0 || cycle_cnt !== 0) begin
            fails++;
            $display("FAIL restart_clear: got done=%b hpc=%h cyc=%0d want 0 0 0",
                     done, halt_pc, cycle_cnt);
        end
        tick(); tick(); tick();
        pc_valid = 1'b1;
        pc = 32'h4000; tick(); tick(); tick();
        pc = 32'h5000; tick(); tick();
        pc_valid = 1'b0;
        tick(); tick();
        pc = 32'h7777; tick();
        pc_valid = 1'b1;
        pc = 32'h5000; tick();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL halt_inv_early: got done=%b want 0", done);
        end
        tick();
        pc_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || halt_pc !== 32'h5000) begin
            fails++;
            $display("FAIL halt_inv_done: got done=%b hpc=%h want 1 5000", done, halt_pc);
        end
    endtask

    task automatic test_timeout();
        int n;
        start_run();
        n = 0;
        pc_valid = 1'b1;
        while (timeout !== 1'b1 && n < 2100) begin
            pc = 32'h1000 + PC_W'(n) * 4;
            tick();
            n++;
        end
        pc_valid = 1'b0;
        tests++;
        if (timeout !== 1'b1 || n != 2000) begin
            fails++;
            $display("FAIL timeout_when: got timeout=%b after %0d cycles want 1 after 2000", timeout, n);
        end
        tests++;
        if (cycle_cnt !== 1999 || done !== 1'b0 || cpu_reset !== 1'b1 || running !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: got cyc=%0d done=%b cpu_reset=%b running=%b want 1999 0 1 0",
                     cycle_cnt, done, cpu_reset, running);
        end
    endtask

    task automatic test_collision();
        start_run();
        pc_valid = 1'b1;
        for (int i = 0; i < 1996; i++) begin
            pc = PC_W'(i) * 4;
            tick();
        end
        pc = 32'hDEAD0000;
        tick(); tick(); tick();
        tests++;
        if (cycle_cnt !== 1999 || done !== 1'b0 || timeout !== 1'b0) begin
            fails++;
            $display("FAIL collide_pre: got cyc=%0d done=%b timeout=%b want 1999 0 0",
                     cycle_cnt, done, timeout);
        end
        tick();
        pc_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || timeout !== 1'b0 || halt_pc !== 32'hDEAD0000 || cycle_cnt !== 1999) begin
            fails++;
            $display("FAIL collide: got done=%b timeout=%b hpc=%h cyc=%0d want 1 0 dead0000 1999",
                     done, timeout, halt_pc, cycle_cnt);
        end
    endtask

    // Retire counting, then abort with priority over start
    task automatic test_retire_abort();
        logic [CNT_W-1:0] exp_ret;
`ifdef RUN_CTRL_PERF_EN
        exp_ret = 10;
`else
        exp_ret = 0;
`endif
        start_run();
        for (int i = 0; i < 15; i++) begin
            retire = (i % 3 != 2);
            tick();
        end
        retire = 1'b0;
        tick();
        tests++;
        if (retire_cnt !== exp_ret || cycle_cnt !== 16) begin
            fails++;
            $display("FAIL retire_cnt: got ret=%0d cyc=%0d want %0d 16", retire_cnt, cycle_cnt, exp_ret);
        end
        abort = 1'b1;
        retire = 1'b1;
        tick();
        abort = 1'b0;
        retire = 1'b0;
        tests++;
        if (running !== 1'b0 || cpu_reset !== 1'b1 || cycle_cnt !== 16 || retire_cnt !== exp_ret) begin
            fails++;
            $display("FAIL abort_run: got running=%b cpu_reset=%b cyc=%0d ret=%0d want 0 1 16 %0d",
                     running, cpu_reset, cycle_cnt, retire_cnt, exp_ret);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick(); tick(); tick(); tick();
        tests++;
        if (running !== 1'b0 || cpu_reset !== 1'b1 || cycle_cnt !== 16) begin
            fails++;
            $display("FAIL abort_over_start: got running=%b cpu_reset=%b cyc=%0d want 0 1 16",
                     running, cpu_reset, cycle_cnt);
        end
    endtask

    task automatic test_midrun_reset();
        start_run();
        pc_valid = 1'b1;
        retire = 1'b1;
        pc = 32'h9000; tick(); tick(); tick();
        reset = 1'b0;
        tick();
        pc_valid = 1'b0;
        retire = 1'b0;
        tests++;
        if ({cpu_reset, running, done, timeout} !== 4'b1000 || cycle_cnt !== 0 ||
            retire_cnt !== 0 || halt_pc !== 0) begin
            fails++;
            $display("FAIL midrun_reset: got flags=%b cyc=%0d ret=%0d hpc=%h want 1000 0 0 0",
                     {cpu_reset, running, done, timeout}, cycle_cnt, retire_cnt, halt_pc);
        end
        reset = 1'b1;
        tick(); tick();
        tests++;
        if (running !== 1'b0 || cpu_reset !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_idle: got running=%b cpu_reset=%b want 0 1", running, cpu_reset);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        pc       = '0;
        pc_valid = 1'b0;
        retire   = 1'b0;
        test_reset();
        test_rst_hold();
        test_halt();
        test_halt_invalid();
        test_timeout();
        test_collision();
        test_retire_abort();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
